// File: rtl/pulse_measure.sv
// Measures high width and period of a signal from its single-cycle edge strobes.
// One registered record per completed period; timeout/saturation yields an overflow record.
module pulse_measure #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raising,
  input  logic             falling,
  input  logic             clr,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             overflow,
  output logic             valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e           state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] pcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      hcnt       <= '0;
      pcnt       <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clr) begin
        state      <= StIdle;
        hcnt       <= '0;
        pcnt       <= '0;
        high_cnt   <= '0;
        period_cnt <= '0;
        overflow   <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (raising) begin
              state <= StHigh;
              hcnt  <= ONE;
              pcnt  <= ONE;
              busy  <= 1'b1;
            end
          end
          StHigh, StLow: begin
            if (raising) begin
              // A raising while still HIGH means the falling edge was missed.
              high_cnt   <= (state == StHigh) ? pcnt : hcnt;
              period_cnt <= pcnt;
              overflow   <= 1'b0;
              valid      <= 1'b1;
              hcnt       <= ONE;
              pcnt       <= ONE;
              state      <= StHigh;
              busy       <= 1'b1;
            end else if (pcnt == MAXC) begin
              high_cnt   <= (state == StHigh) ? MAXC : hcnt;
              period_cnt <= MAXC;
              overflow   <= 1'b1;
              valid      <= 1'b1;
              hcnt       <= '0;
              pcnt       <= '0;
              state      <= StIdle;
              busy       <= 1'b0;
            end else if (state == StHigh && falling) begin
              state <= StLow;
              pcnt  <= pcnt + ONE;
            end else begin
              pcnt <= pcnt + ONE;
              if (state == StHigh) hcnt <= hcnt + ONE;
            end
          end
          default: begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Self-checking bench for pulse_measure: table of strobe steps plus hand-written
// timeout / reset sequences; expected records go through a due-cycle scoreboard.
module tb_pulse_measure;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         raising;
  logic         falling;
  logic         clr;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         overflow;
  logic         valid;
  logic         busy;

  always #5 clk = ~clk;

  pulse_measure #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raising   (raising),
    .falling   (falling),
    .clr       (clr),
    .high_cnt  (high_cnt),
    .period_cnt(period_cnt),
    .overflow  (overflow),
    .valid     (valid),
    .busy      (busy)
  );

  typedef struct {
    int           due;
    logic [W-1:0] h;
    logic [W-1:0] p;
    logic         o;
  } rec_t;

  typedef struct {
    int           pre;
    logic         r;
    logic         f;
    logic         c;
    logic         rec;
    logic [W-1:0] h;
    logic [W-1:0] p;
    logic         busy;
  } vec_t;

  rec_t         sb[$];
  vec_t         tbl[21];
  int           checks = 0;
  int           errors = 0;
  int           cyc;
  logic [W-1:0] hold_h;
  logic [W-1:0] hold_p;
  logic         hold_o;
  logic         exp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] p, input logic o);
    rec_t r;
    r.due = cyc + 1;
    r.h   = h;
    r.p   = p;
    r.o   = o;
    sb.push_back(r);
  endtask

  task automatic check_cycle();
    rec_t r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk("valid_expected", 32'(valid), 32'd1);
      hold_h = r.h;
      hold_p = r.p;
      hold_o = r.o;
    end else begin
      chk("valid_unexpected", 32'(valid), 32'd0);
    end
    chk("high_cnt", 32'(high_cnt), 32'(hold_h));
    chk("period_cnt", 32'(period_cnt), 32'(hold_p));
    chk("overflow", 32'(overflow), 32'(hold_o));
    chk("busy", 32'(busy), 32'(exp_busy));
  endtask

  // Inputs apply to cycle cyc; outputs are checked 1 time unit after the edge.
  task automatic step(input logic r, input logic f, input logic c);
    raising = r;
    falling = f;
    clr     = c;
    @(posedge clk);
    #1;
    raising = 1'b0;
    falling = 1'b0;
    clr     = 1'b0;
    cyc++;
    if (c) begin
      hold_h = '0;
      hold_p = '0;
      hold_o = 1'b0;
    end
    check_cycle();
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    raising  = 1'b0;
    falling  = 1'b0;
    clr      = 1'b0;
    hold_h   = '0;
    hold_p   = '0;
    hold_o   = 1'b0;
    exp_busy = 1'b0;
    cyc      = 0;

    // Fields: pre-idle cycles, raising, falling, clr, record?, high, period, busy after.
    tbl[0]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // r @10
    tbl[1]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // f @13
    tbl[2]  = '{6,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd10, 1'b1}; // r @20
    tbl[3]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // f @25
    tbl[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd12, 1'b1}; // r @32
    tbl[5]  = '{3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd4,  1'b1}; // missed falling @36
    tbl[6]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // f @38
    tbl[7]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // spurious f in LOW @40
    tbl[8]  = '{2,  1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 4'd7,  1'b1}; // r+f in LOW @43
    tbl[9]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // f @46
    tbl[10] = '{3,  1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd7,  1'b1}; // r @50
    tbl[11] = '{2,  1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3,  1'b1}; // r+f in HIGH @53
    tbl[12] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // f @55
    tbl[13] = '{4,  1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd7,  1'b1}; // r @60
    tbl[14] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  1'b0}; // clr+r mid-HIGH @62
    tbl[15] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b0}; // spurious f in IDLE @64
    tbl[16] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // r @66
    tbl[17] = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // f @68
    tbl[18] = '{6,  1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd9,  1'b1}; // r @75
    tbl[19] = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  1'b0}; // clr while valid @76
    tbl[20] = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  1'b1}; // r @80

    repeat (3) step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;

    for (int i = 0; i < 21; i++) begin
      for (int j = 0; j < tbl[i].pre; j++) step(1'b0, 1'b0, 1'b0);
      exp_busy = tbl[i].busy;
      if (tbl[i].rec) push(tbl[i].h, tbl[i].p, 1'b0);
      step(tbl[i].r, tbl[i].f, tbl[i].c);
    end

    // Timeout while HIGH: raising @80, pcnt hits 15 @95, record @96.
    idle_until(95);
    exp_busy = 1'b0;
    push(4'd15, 4'd15, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Fresh measurement after timeout.
    idle_until(100);
    exp_busy = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    idle_until(104);
    step(1'b0, 1'b1, 1'b0);
    idle_until(110);
    push(4'd4, 4'd10, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Timeout while LOW keeps the frozen high count.
    idle_until(113);
    step(1'b0, 1'b1, 1'b0);
    idle_until(125);
    exp_busy = 1'b0;
    push(4'd3, 4'd15, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Raising exactly at pcnt == MAXC is a normal record.
    idle_until(130);
    exp_busy = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    idle_until(145);
    push(4'd15, 4'd15, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle_until(148);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-LOW, not aligned to the clock.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_high_cnt", 32'(high_cnt), 32'd0);
    chk("rst_async_period_cnt", 32'(period_cnt), 32'd0);
    chk("rst_async_overflow", 32'(overflow), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    hold_h   = '0;
    hold_p   = '0;
    hold_o   = 1'b0;
    exp_busy = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Strays after reset must not produce a record before a full period.
    step(1'b0, 1'b1, 1'b0);
    exp_busy = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    push(4'd4, 4'd10, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
